// File: rtl/net_data_receiver_pkg.sv
// Shared framing constants, packet layouts and receive FSM encoding for the
// five-wire link receiver.
package net_data_receiver_pkg;

    localparam int ENC_DATA_BITS     = 218;
    localparam int ENC_HEAD_BITS     = 12;
    localparam int GBG_BITS          = 4;
    localparam int DATA_PAD_BITS     = 9;
    localparam int HEAD_PAD_BITS     = 4;
    localparam int NUM_DATA_LINES    = 4;
    localparam int LINE_PAYLOAD_BITS = ENC_DATA_BITS - DATA_PAD_BITS;
    localparam int PKT_BITS          = NUM_DATA_LINES * LINE_PAYLOAD_BITS;

    localparam logic [3:0] HND_TYPE_ACK  = 4'b1111;
    localparam logic [3:0] HND_TYPE_LOST = 4'b0000;

    typedef logic [3:0] tile_type_t;

    typedef struct packed {
        logic [3:0]          seq;
        logic [GBG_BITS-1:0] garbage;
        tile_type_t          hold;
        logic [23:0]         piece_queue;
        logic [799:0]        playfield;
    } data_pkt_t;

    typedef struct packed {
        logic [HEAD_PAD_BITS-1:0] pad;
        logic [3:0]               seq;
        logic [3:0]               kind;
    } hnd_head_t;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_CHECK   = 2'd2
    } rx_state_t;

    // The 1-bit sequence number is sent as four identical copies.
    function automatic logic copies_agree(input logic [3:0] copies);
        return (copies == 4'b0000) || (copies == 4'b1111);
    endfunction

endpackage

// File: rtl/serial_line_rx.sv
// Single-wire deserializer: idle-low line, start bit of 1, then WIDTH payload
// bits MSB first; done pulses for one cycle with the assembled word.
module serial_line_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_active,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word_out,
    output logic             done
);

    typedef enum logic [1:0] {
        LN_IDLE  = 2'd0,
        LN_SHIFT = 2'd1,
        LN_DONE  = 2'd2
    } ln_state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);

    ln_state_t        state;
    ln_state_t        state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LN_IDLE;
        end else if (!game_active) begin
            state <= LN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The DONE cycle ignores the line, so a new start bit is taken one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            LN_IDLE:  if (serial_in) state_next = LN_SHIFT;
            LN_SHIFT: if (last_bit) state_next = LN_DONE;
            LN_DONE:  state_next = LN_IDLE;
            default:  state_next = LN_IDLE;
        endcase
    end

    assign done = (state == LN_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            word_out <= '0;
        end else if (state == LN_SHIFT && game_active) begin
            bit_cnt  <= bit_cnt + 1'b1;
            word_out <= {word_out[WIDTH-2:0], serial_in};
        end else begin
            bit_cnt  <= '0;
        end
    end

endmodule

// File: rtl/net_data_receiver.sv
// Receive side of the five-wire link: reassembles and validates data packets,
// enforces alternating-bit sequencing and decodes handshake frames.
module net_data_receiver
    import net_data_receiver_pkg::*;
#(
    parameter int SKEW_LIMIT   = 16,
    parameter int ERR_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    game_active,
    input  logic                    serial_in_h,
    input  logic                    serial_in_0,
    input  logic                    serial_in_1,
    input  logic                    serial_in_2,
    input  logic                    serial_in_3,
    output logic                    data_valid,
    output logic [GBG_BITS-1:0]     garbage,
    output tile_type_t              hold,
    output logic [23:0]             piece_queue_packed,
    output logic [799:0]            playfield_packed,
    output logic                    send_ready_ACK,
    output logic                    ack_seqNum,
    output logic                    ack_received,
    output logic                    received_seqNum_h,
    output logic                    game_lost_received,
    output logic                    expected_seqNum,
    output logic [ERR_CNT_BITS-1:0] err_cnt
);

    localparam int SKEW_W = $clog2(SKEW_LIMIT + 1);

    logic [NUM_DATA_LINES-1:0] line_serial;
    logic [NUM_DATA_LINES-1:0] line_done;
    logic [ENC_DATA_BITS-1:0]  line_word [NUM_DATA_LINES];
    logic [ENC_DATA_BITS-1:0]  cap_word  [NUM_DATA_LINES];
    logic [ENC_HEAD_BITS-1:0]  hnd_word;
    logic                      hnd_done;

    assign line_serial = {serial_in_3, serial_in_2, serial_in_1, serial_in_0};

    for (genvar g = 0; g < NUM_DATA_LINES; g++) begin : g_line
        serial_line_rx #(.WIDTH(ENC_DATA_BITS)) u_rx (
            .clk        (clk),
            .rst        (rst),
            .game_active(game_active),
            .serial_in  (line_serial[g]),
            .word_out   (line_word[g]),
            .done       (line_done[g])
        );
    end

    serial_line_rx #(.WIDTH(ENC_HEAD_BITS)) u_rx_h (
        .clk        (clk),
        .rst        (rst),
        .game_active(game_active),
        .serial_in  (serial_in_h),
        .word_out   (hnd_word),
        .done       (hnd_done)
    );

    // Words are held here because a deserializer may begin its next frame
    // before the slowest line of this packet has finished.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DATA_LINES; i++) begin
            if (line_done[i]) cap_word[i] <= line_word[i];
        end
    end

    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [NUM_DATA_LINES-1:0] done_mask;
    logic [SKEW_W-1:0]         skew_cnt;
    logic                      skew_hit;
    logic                      overlap;
    logic                      all_done;

    assign skew_hit = (skew_cnt == SKEW_W'(SKEW_LIMIT));
    assign overlap  = |(line_done & done_mask);
    assign all_done = &(line_done | done_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else if (!game_active) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE: begin
                if (&line_done)      state_next = RX_CHECK;
                else if (|line_done) state_next = RX_COLLECT;
            end
            RX_COLLECT: begin
                if (skew_hit || overlap) state_next = RX_IDLE;
                else if (all_done)       state_next = RX_CHECK;
            end
            RX_CHECK: state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // The skew counter reads N on the Nth cycle after the first line completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_mask <= '0;
            skew_cnt  <= '0;
        end else if (!game_active || state_next != RX_COLLECT) begin
            done_mask <= '0;
            skew_cnt  <= '0;
        end else if (state == RX_IDLE) begin
            done_mask <= line_done;
            skew_cnt  <= SKEW_W'(1);
        end else begin
            done_mask <= done_mask | line_done;
            skew_cnt  <= skew_cnt + 1'b1;
        end
    end

    data_pkt_t pkt;
    hnd_head_t hnd;
    logic      pad_ok;
    logic      collect_err;
    logic      check_pass;
    logic      check_fail;
    logic      in_order;
    logic      hnd_ok;
    logic      hnd_ack;
    logic      hnd_lost;
    logic      hnd_err;

    assign pkt = {cap_word[0][LINE_PAYLOAD_BITS-1:0], cap_word[1][LINE_PAYLOAD_BITS-1:0],
                  cap_word[2][LINE_PAYLOAD_BITS-1:0], cap_word[3][LINE_PAYLOAD_BITS-1:0]};
    assign hnd = hnd_word;

    always_comb begin
        pad_ok = 1'b1;
        for (int i = 0; i < NUM_DATA_LINES; i++) begin
            if (cap_word[i][ENC_DATA_BITS-1 -: DATA_PAD_BITS] != '0) pad_ok = 1'b0;
        end
    end

    always_comb begin
        collect_err = (state == RX_COLLECT) && (skew_hit || overlap);
        check_pass  = (state == RX_CHECK) && pad_ok && copies_agree(pkt.seq);
        check_fail  = (state == RX_CHECK) && !(pad_ok && copies_agree(pkt.seq));
        in_order    = (pkt.seq[0] == expected_seqNum);
        hnd_ok      = (hnd.pad == '0) && copies_agree(hnd.seq);
        hnd_ack     = hnd_done && hnd_ok && (hnd.kind == HND_TYPE_ACK);
        hnd_lost    = hnd_done && hnd_ok && (hnd.kind == HND_TYPE_LOST);
        hnd_err     = hnd_done && !(hnd_ack || hnd_lost);
    end

    function automatic logic [ERR_CNT_BITS-1:0] err_add(input logic [ERR_CNT_BITS-1:0] cnt,
                                                        input logic [1:0] inc);
        logic [ERR_CNT_BITS:0] sum;
        sum = {1'b0, cnt} + (ERR_CNT_BITS + 1)'(inc);
        return sum[ERR_CNT_BITS] ? '1 : sum[ERR_CNT_BITS-1:0];
    endfunction

    logic [1:0] err_inc;
    assign err_inc = {1'b0, collect_err | check_fail} + {1'b0, hnd_err};

    // Registered results: pulses are suppressed while the game is inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid         <= 1'b0;
            garbage            <= '0;
            hold               <= '0;
            piece_queue_packed <= '0;
            playfield_packed   <= '0;
            send_ready_ACK     <= 1'b0;
            ack_seqNum         <= 1'b0;
            ack_received       <= 1'b0;
            received_seqNum_h  <= 1'b0;
            game_lost_received <= 1'b0;
            expected_seqNum    <= 1'b0;
            err_cnt            <= '0;
        end else begin
            data_valid         <= 1'b0;
            send_ready_ACK     <= 1'b0;
            ack_received       <= 1'b0;
            game_lost_received <= 1'b0;
            if (game_active) begin
                if (check_pass) begin
                    send_ready_ACK <= 1'b1;
                    ack_seqNum     <= ~pkt.seq[0];
                    if (in_order) begin
                        data_valid         <= 1'b1;
                        garbage            <= pkt.garbage;
                        hold               <= pkt.hold;
                        piece_queue_packed <= pkt.piece_queue;
                        playfield_packed   <= pkt.playfield;
                        expected_seqNum    <= ~expected_seqNum;
                    end
                end
                if (hnd_ack) begin
                    ack_received      <= 1'b1;
                    received_seqNum_h <= hnd.seq[0];
                end
                if (hnd_lost) game_lost_received <= 1'b1;
                err_cnt <= err_add(err_cnt, err_inc);
            end
        end
    end

endmodule

// File: tb/tb_net_data_receiver.sv
// Directed and randomized checks of net_data_receiver against a rule-level model.
module tb_net_data_receiver;

    localparam int SKEW_LIMIT = 16;
    localparam int ERR_MAX    = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         game_active;
    logic         serial_in_h;
    logic [3:0]   sin;
    logic         data_valid;
    logic [3:0]   garbage;
    logic [3:0]   hold;
    logic [23:0]  piece_queue_packed;
    logic [799:0] playfield_packed;
    logic         send_ready_ACK;
    logic         ack_seqNum;
    logic         ack_received;
    logic         received_seqNum_h;
    logic         game_lost_received;
    logic         expected_seqNum;
    logic [3:0]   err_cnt;

    always #5 clk = ~clk;

    net_data_receiver #(.SKEW_LIMIT(SKEW_LIMIT), .ERR_CNT_BITS(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .game_active       (game_active),
        .serial_in_h       (serial_in_h),
        .serial_in_0       (sin[0]),
        .serial_in_1       (sin[1]),
        .serial_in_2       (sin[2]),
        .serial_in_3       (sin[3]),
        .data_valid        (data_valid),
        .garbage           (garbage),
        .hold              (hold),
        .piece_queue_packed(piece_queue_packed),
        .playfield_packed  (playfield_packed),
        .send_ready_ACK    (send_ready_ACK),
        .ack_seqNum        (ack_seqNum),
        .ack_received      (ack_received),
        .received_seqNum_h (received_seqNum_h),
        .game_lost_received(game_lost_received),
        .expected_seqNum   (expected_seqNum),
        .err_cnt           (err_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic         m_exp = 1'b0;
    int           m_err = 0;
    logic [3:0]   m_gbg = '0;
    logic [3:0]   m_hold = '0;
    logic [23:0]  m_queue = '0;
    logic [799:0] m_pf = '0;
    logic         m_ack_seq = 1'b0;
    logic         m_rseq = 1'b0;

    // Observations of one transfer
    int   dv_cnt, dv_at, sra_cnt, sra_at, ar_cnt, ar_at, gl_cnt, gl_at;
    logic sra_seq;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [835:0] mk_pkt(input logic seq, input logic [3:0] g,
                                            input logic [3:0] h, input logic [23:0] q,
                                            input logic [799:0] pf);
        return {{4{seq}}, g, h, q, pf};
    endfunction

    function automatic logic [799:0] rnd_pf();
        logic [799:0] v;
        for (int i = 0; i < 25; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Drives one transfer; all lines idle low outside their frames.
    task automatic xfer(input bit data_en, input logic [835:0] pkt, input logic [35:0] pads,
                        input int o0, input int o1, input int o2, input int o3,
                        input bit hs_en, input logic [11:0] hs_word, input int hs_off,
                        input int drop_at);
        int           off [4];
        logic [217:0] w [4];
        int           n_iter;
        int           last;
        off = '{o0, o1, o2, o3};
        last = 0;
        for (int i = 0; i < 4; i++) begin
            w[i] = {pads[35-9*i -: 9], pkt[835-209*i -: 209]};
            if (off[i] > last) last = off[i];
        end
        n_iter = data_en ? last + 230 : 0;
        if (hs_en && hs_off + 20 > n_iter) n_iter = hs_off + 20;
        dv_cnt = 0; dv_at = -1; sra_cnt = 0; sra_at = -1; sra_seq = 1'bx;
        ar_cnt = 0; ar_at = -1; gl_cnt = 0; gl_at = -1;
        for (int t = 0; t < n_iter; t++) begin
            int p;
            @(negedge clk);
            if (data_valid) begin dv_cnt++; dv_at = t; end
            if (send_ready_ACK) begin sra_cnt++; sra_at = t; sra_seq = ack_seqNum; end
            if (ack_received) begin ar_cnt++; ar_at = t; end
            if (game_lost_received) begin gl_cnt++; gl_at = t; end
            game_active = !(drop_at >= 0 && t >= drop_at && t < drop_at + 3);
            for (int i = 0; i < 4; i++) begin
                p = t - off[i];
                sin[i] = 1'b0;
                if (data_en && !(drop_at >= 0 && t >= drop_at) && p >= 0 && p <= 218)
                    sin[i] = (p == 0) ? 1'b1 : w[i][218-p];
            end
            p = t - hs_off;
            serial_in_h = 1'b0;
            if (hs_en && p >= 0 && p <= 12) serial_in_h = (p == 0) ? 1'b1 : hs_word[12-p];
        end
        game_active = 1'b1;
    endtask

    // Predicts the outcome from the link rules, runs the transfer and compares.
    task automatic run(input string tag, input bit data_en, input logic [835:0] pkt,
                       input logic [35:0] pads, input int o0, input int o1, input int o2,
                       input int o3, input bit hs_en, input logic [11:0] hs_word,
                       input int hs_off, input int drop_at);
        int first, last;
        bit d_ok, d_err, acc, h_ok, h_ack, h_lost, h_err;
        first = o0; last = o0;
        if (o1 < first) first = o1;
        if (o2 < first) first = o2;
        if (o3 < first) first = o3;
        if (o1 > last) last = o1;
        if (o2 > last) last = o2;
        if (o3 > last) last = o3;
        d_ok   = data_en && drop_at < 0 && pads == '0 &&
                 (pkt[835:832] == 4'h0 || pkt[835:832] == 4'hF) && (last - first) < SKEW_LIMIT;
        d_err  = data_en && drop_at < 0 && !d_ok;
        acc    = d_ok && (pkt[832] == m_exp);
        h_ok   = hs_en && hs_word[11:8] == 4'h0 && (hs_word[7:4] == 4'h0 || hs_word[7:4] == 4'hF);
        h_ack  = h_ok && hs_word[3:0] == 4'hF;
        h_lost = h_ok && hs_word[3:0] == 4'h0;
        h_err  = hs_en && !(h_ack || h_lost);

        xfer(data_en, pkt, pads, o0, o1, o2, o3, hs_en, hs_word, hs_off, drop_at);

        chk({tag, ".dv_count"}, dv_cnt, acc);
        if (acc) chk({tag, ".dv_cycle"}, dv_at, last + 221);
        chk({tag, ".ackreq_count"}, sra_cnt, d_ok);
        if (d_ok) begin
            chk({tag, ".ackreq_cycle"}, sra_at, last + 221);
            chk({tag, ".ackreq_seq"}, sra_seq, !pkt[832]);
            m_ack_seq = !pkt[832];
        end
        chk({tag, ".ack_rx_count"}, ar_cnt, h_ack);
        if (h_ack) begin
            chk({tag, ".ack_rx_cycle"}, ar_at, hs_off + 14);
            m_rseq = hs_word[4];
        end
        chk({tag, ".lost_count"}, gl_cnt, h_lost);
        if (h_lost) chk({tag, ".lost_cycle"}, gl_at, hs_off + 14);
        if (acc) begin
            m_gbg   = pkt[831:828];
            m_hold  = pkt[827:824];
            m_queue = pkt[823:800];
            m_pf    = pkt[799:0];
            m_exp   = !m_exp;
        end
        m_err = m_err + int'(d_err) + int'(h_err);
        if (m_err > ERR_MAX) m_err = ERR_MAX;

        chk({tag, ".garbage"}, garbage, m_gbg);
        chk({tag, ".hold"}, hold, m_hold);
        chk({tag, ".queue"}, piece_queue_packed, m_queue);
        n_vec++;
        assert (playfield_packed === m_pf)
        else begin
            n_err++;
            $error("FAIL %s.playfield: observed low %h expected low %h", tag,
                   playfield_packed[127:0], m_pf[127:0]);
        end
        chk({tag, ".expected_seq"}, expected_seqNum, m_exp);
        chk({tag, ".ack_seq"}, ack_seqNum, m_ack_seq);
        chk({tag, ".rx_seq_h"}, received_seqNum_h, m_rseq);
        chk({tag, ".err_cnt"}, err_cnt, m_err);
    endtask

    logic [799:0] pf0;
    logic [835:0] pk;
    logic [835:0] pk_a;
    logic [35:0]  pads_r;
    logic [11:0]  hw;
    bit           hs_r;

    initial begin
        rst = 1'b1; game_active = 1'b1; sin = '0; serial_in_h = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // A partial data frame and handshake frame, cut short by reset.
        @(negedge clk); sin[0] = 1'b1; serial_in_h = 1'b1;
        repeat (40) begin @(negedge clk); sin[0] = $urandom_range(0, 1); serial_in_h = $urandom_range(0, 1); end
        rst = 1'b1; sin = '0; serial_in_h = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset.data_valid", data_valid, 0);
        chk("reset.garbage", garbage, 0);
        chk("reset.hold", hold, 0);
        chk("reset.queue", piece_queue_packed, 0);
        chk("reset.playfield_nonzero", |playfield_packed, 0);
        chk("reset.send_ready_ACK", send_ready_ACK, 0);
        chk("reset.ack_seqNum", ack_seqNum, 0);
        chk("reset.ack_received", ack_received, 0);
        chk("reset.received_seqNum_h", received_seqNum_h, 0);
        chk("reset.game_lost_received", game_lost_received, 0);
        chk("reset.expected_seqNum", expected_seqNum, 0);
        chk("reset.err_cnt", err_cnt, 0);

        // In-order stream with one retransmit
        pf0 = '0; pf0[3:0] = 4'd2;
        pk_a = mk_pkt(1'b0, 4'd3, 4'd5, 24'h0, pf0);
        run("pkt0", 1, pk_a, '0, 0, 0, 0, 0, 0, '0, 0, -1);
        chk("pkt0.tile00", playfield_packed[3:0], 2);
        chk("pkt0.ack_seq_is_1", ack_seqNum, 1);
        run("retransmit", 1, pk_a, '0, 0, 0, 0, 0, 0, '0, 0, -1);
        run("pkt1", 1, mk_pkt(1'b1, 4'($urandom), 4'($urandom), 24'($urandom), rnd_pf()), '0,
            3, 0, 7, 2, 0, '0, 0, -1);
        run("pkt2", 1, mk_pkt(1'b0, 4'($urandom), 4'($urandom), 24'($urandom), rnd_pf()), '0,
            0, 5, 1, 9, 0, '0, 0, -1);
        run("pkt3", 1, mk_pkt(1'b1, 4'($urandom), 4'($urandom), 24'($urandom), rnd_pf()), '0,
            1, 1, 1, 1, 0, '0, 0, -1);

        // Skew limit
        pk = mk_pkt(1'b0, 4'd7, 4'd1, 24'hABCDEF, rnd_pf());
        run("skew16", 1, pk, '0, 0, 0, 0, 16, 0, '0, 0, -1);
        run("skew15", 1, pk, '0, 0, 0, 0, 15, 0, '0, 0, -1);

        // Corruption
        pk = mk_pkt(m_exp, 4'd2, 4'd2, 24'h123456, rnd_pf());
        pk[835:832] = 4'b0100;
        run("seq_copies", 1, pk, '0, 0, 0, 0, 0, 0, '0, 0, -1);
        pk = mk_pkt(m_exp, 4'd2, 4'd2, 24'h123456, rnd_pf());
        run("pad_bit", 1, pk, 36'h1 << 20, 0, 0, 0, 0, 0, '0, 0, -1);

        // Handshake frames
        run("hs_ack", 0, '0, '0, 0, 0, 0, 0, 1, 12'h0FF, 0, -1);
        run("hs_lost", 0, '0, '0, 0, 0, 0, 0, 1, 12'h000, 0, -1);
        run("hs_badtype", 0, '0, '0, 0, 0, 0, 0, 1, 12'h00A, 0, -1);
        run("hs_badpad", 0, '0, '0, 0, 0, 0, 0, 1, 12'h1FF, 0, -1);
        run("hs_badseq", 0, '0, '0, 0, 0, 0, 0, 1, 12'h05F, 0, -1);
        run("hs_ack0", 0, '0, '0, 0, 0, 0, 0, 1, 12'h00F, 3, -1);

        // Handshake pulse coinciding with data pulse, then two errors in one cycle
        run("coincide_ok", 1, mk_pkt(m_exp, 4'd9, 4'd4, 24'h0F0F0F, rnd_pf()), '0,
            0, 0, 0, 0, 1, 12'h0FF, 207, -1);
        run("coincide_err", 1, mk_pkt(m_exp, 4'd9, 4'd4, 24'h0F0F0F, rnd_pf()), 36'h1 << 30,
            0, 0, 0, 0, 1, 12'h0FA, 207, -1);

        // game_active dropped mid-frame, then a clean packet
        pk = mk_pkt(m_exp, 4'd6, 4'd8, 24'h555AAA, rnd_pf());
        run("drop", 1, pk, '0, 0, 0, 0, 0, 0, '0, 0, 100);
        run("after_drop", 1, pk, '0, 0, 0, 0, 0, 0, '0, 0, -1);

        // Randomized traffic
        for (int k = 0; k < 10; k++) begin
            pk = mk_pkt(1'($urandom), 4'($urandom), 4'($urandom), 24'($urandom), rnd_pf());
            if ($urandom_range(0, 5) == 0) pk[835:832] = 4'($urandom);
            pads_r = ($urandom_range(0, 4) == 0) ? (36'h1 << $urandom_range(0, 35)) : '0;
            hs_r = 1'($urandom);
            case ($urandom_range(0, 3))
                0: hw = 12'h0FF;
                1: hw = 12'h00F;
                2: hw = 12'h000;
                default: hw = 12'($urandom);
            endcase
            run("random", 1, pk, pads_r, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15), hs_r, hw,
                $urandom_range(0, 240), -1);
        end

        // Saturation
        for (int k = 0; k < 20; k++) run("saturate", 0, '0, '0, 0, 0, 0, 0, 1, 12'h0F5, 0, -1);
        chk("saturate.err_cnt_max", err_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
